ascon_fsm_ctrl: RTL and testbench
=================================

Name: ascon_fsm_ctrl

Overview:
- Moore/Mealy control FSM that sequences one ASCON-128 encryption: initialisation p^12, NB_AD associated-data blocks each followed by p^6, NB_PT plaintext blocks, then finalisation p^12.
- Drives the round counter (en/init_a/init_b) and reads its value back.
- Generates every enable for the permutation datapath: state mux, XOR stages, cipher and tag registers.
- Handshakes with the data source.

Parameters:
- NB_AD, 1, number of 64-bit associated-data blocks (>=1).
- NB_PT, 4, number of 64-bit plaintext blocks (>=1).

Ports:
- clock_i  in  1  system clock
- resetb_i  in  1  asynchronous active-low reset
- start_i  in  1  start one encryption (sampled in IDLE only)
- data_valid_i  in  1  upstream block is present and held stable
- cpt_i  in  4  round counter value
- en_cpt_o  out  1  round counter enable
- init_a_o  out  1  load counter with 0 (p^12)
- init_b_o  out  1  load counter with 6 (p^6)
- init_state_sel_o  out  1  permutation input = IV||K||N
- en_reg_state_o  out  1  state register load
- en_xor_data_begin_o  out  1  XOR data block into rate at permutation input
- en_xor_key_begin_o  out  1  XOR K into capacity at input
- en_xor_key_end_o  out  1  XOR 0*||K at permutation output
- en_xor_lsb_end_o  out  1  XOR domain-separation bit at output
- en_cipher_o  out  1  capture ciphertext block
- en_tag_o  out  1  capture tag
- data_ack_o  out  1  block consumed; upstream may change data next cycle
- cipher_valid_o  out  1  ciphertext register updated (1 cycle after en_cipher_o)
- busy_o  out  1  high outside IDLE
- done_o  out  1  one-cycle end pulse

Behaviour:
- Reset (async, resetb_i=0):
  - state=IDLE; both block counters=0.
  - All outputs=0, including registered cipher_valid_o.
  - Takes effect mid-operation immediately; the run is abandoned with no done_o.
- States: IDLE, INIT_SET, INIT_RUN, AD_WAIT, AD_RUN, PT_WAIT, PT_RUN, FIN_RUN, DONE.
- IDLE:
  - start_i=1 goes to INIT_SET.
  - data_valid_i is ignored.
- INIT_SET:
  - en_cpt_o=init_a_o=1.
  - Next state INIT_RUN; cpt_i=0 on the first INIT_RUN cycle.
- INIT_RUN:
  - en_cpt_o=en_reg_state_o=1 every cycle.
  - init_state_sel_o=1 when cpt_i=0.
  - en_xor_key_end_o=1 when cpt_i=11, then go to AD_WAIT.
- AD_WAIT:
  - Stays until data_valid_i=1.
  - On valid: en_cpt_o=init_b_o=1, go to AD_RUN.
- AD_RUN (cpt_i 6..11):
  - en_cpt_o=en_reg_state_o=1 every cycle.
  - At cpt_i=6: en_xor_data_begin_o=data_ack_o=1.
  - At cpt_i=11: ad_cnt increments.
  - If this is block NB_AD (last): en_xor_lsb_end_o=1 and go to PT_WAIT; else go to AD_WAIT.
- PT_WAIT, on data_valid_i=1:
  - Not last block (pt_cnt<NB_PT-1): en_cpt_o=init_b_o=1, go to PT_RUN.
  - Last block: en_cpt_o=init_a_o=1, go to FIN_RUN.
- PT_RUN (cpt_i 6..11):
  - At cpt_i=6: en_xor_data_begin_o=en_cipher_o=data_ack_o=1.
  - At cpt_i=11: pt_cnt increments, go to PT_WAIT.
- FIN_RUN (cpt_i 0..11):
  - At cpt_i=0: en_xor_data_begin_o=en_cipher_o=data_ack_o=en_xor_key_begin_o=1. The last PT block XOR and the key XOR happen in the same cycle.
  - At cpt_i=11: en_xor_key_end_o=en_tag_o=1, go to DONE.
- DONE:
  - done_o=1 for one cycle; both counters cleared; next state IDLE.
- cipher_valid_o = en_cipher_o delayed one cycle (registered).
- Permutation runs: en_reg_state_o=1 on every RUN cycle; never asserted in WAIT/SET/IDLE/DONE.
- Round exit is decided on cpt_i=11 only. Counter wrap is never relied on: en_cpt_o is 0 outside SET/RUN and WAIT-accept cycles.
- Block counters:
  - ad_cnt width $clog2(NB_AD+1); pt_cnt width $clog2(NB_PT+1).
  - NB_PT=1: the first PT_WAIT accept goes straight to FIN_RUN.
- Ignored inputs:
  - start_i while busy is ignored.
  - data_valid_i in RUN/SET/DONE is ignored; data_ack_o is never asserted without a prior WAIT accept.
- All outputs except cipher_valid_o are combinational from state, cpt_i and data_valid_i.

Test Plan:
- Nominal, NB_AD=1, NB_PT=4, data_valid_i tied 1, start_i pulsed at cycle 0 -> INIT_SET at 1; INIT_RUN 2-13; AD_RUN 15-20; PT_RUN 22-27, 29-34, 36-41; FIN_RUN 43-54; done_o at cycle 55 only.
- Same run, checking key-XOR and tag enables -> en_xor_key_end_o high at cycles 13 and 54 only; en_tag_o at 54 only; en_xor_lsb_end_o at 20 only.
- Same run, checking cipher enables -> en_cipher_o at 22, 29, 36, 43; cipher_valid_o at 23, 30, 37, 44; exactly 5 data_ack_o pulses.
- Stalled source: data_valid_i low 5 cycles in each WAIT -> FSM holds; en_cpt_o=0 and en_reg_state_o=0 throughout; done_o delayed by exactly 25 cycles versus nominal.
- resetb_i pulsed low during PT_RUN -> all outputs 0 immediately; start_i afterwards gives a full nominal sequence.
- start_i re-asserted during FIN_RUN, and NB_PT=1 variant -> no restart; with NB_PT=1 the first PT accept asserts init_a_o and done_o occurs at cycle 34.

Source files
------------

// File: rtl/ascon_fsm_ctrl.sv
// ascon_fsm_ctrl: control FSM sequencing one ASCON-128 encryption.
// Init p^12, NB_AD AD blocks (p^6 each), NB_PT PT blocks, final p^12.
//
// Ports:
//   clock_i, resetb_i     clock, async active-low reset
//   start_i               start one encryption (IDLE only)
//   data_valid_i          upstream block present and stable
//   cpt_i                 round counter value
//   en_cpt_o              round counter enable
//   init_a_o / init_b_o   load counter with 0 / 6
//   init_state_sel_o      permutation input = IV||K||N
//   en_reg_state_o        state register load
//   en_xor_data_begin_o   XOR data into rate at input
//   en_xor_key_begin_o    XOR K into capacity at input
//   en_xor_key_end_o      XOR 0*||K at output
//   en_xor_lsb_end_o      XOR domain-separation bit at output
//   en_cipher_o           capture ciphertext block
//   en_tag_o              capture tag
//   data_ack_o            block consumed
//   cipher_valid_o        en_cipher_o delayed one cycle
//   busy_o                high outside IDLE
//   done_o                one-cycle end pulse
module ascon_fsm_ctrl #(
  parameter int NB_AD = 1,
  parameter int NB_PT = 4
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  input  logic [3:0] cpt_i,
  output logic       en_cpt_o,
  output logic       init_a_o,
  output logic       init_b_o,
  output logic       init_state_sel_o,
  output logic       en_reg_state_o,
  output logic       en_xor_data_begin_o,
  output logic       en_xor_key_begin_o,
  output logic       en_xor_key_end_o,
  output logic       en_xor_lsb_end_o,
  output logic       en_cipher_o,
  output logic       en_tag_o,
  output logic       data_ack_o,
  output logic       cipher_valid_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int ADW = $clog2(NB_AD + 1);
  localparam int PTW = $clog2(NB_PT + 1);
  localparam logic [ADW-1:0] AD_LAST = ADW'(NB_AD - 1);
  localparam logic [PTW-1:0] PT_LAST = PTW'(NB_PT - 1);

  typedef enum logic [3:0] {
    IDLE,
    INIT_SET,
    INIT_RUN,
    AD_WAIT,
    AD_RUN,
    PT_WAIT,
    PT_RUN,
    FIN_RUN,
    DONE
  } state_t;

  state_t         state;
  logic [ADW-1:0] ad_cnt;
  logic [PTW-1:0] pt_cnt;

  logic c0;
  logic c6;
  logic c11;
  logic ad_last;
  logic pt_last;

  assign c0      = (cpt_i == 4'd0);
  assign c6      = (cpt_i == 4'd6);
  assign c11     = (cpt_i == 4'd11);
  assign ad_last = (ad_cnt == AD_LAST);
  assign pt_last = (pt_cnt == PT_LAST);

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state          <= IDLE;
      ad_cnt         <= '0;
      pt_cnt         <= '0;
      cipher_valid_o <= 1'b0;
    end else begin
      cipher_valid_o <= en_cipher_o;
      unique case (state)
        IDLE: begin
          if (start_i) state <= INIT_SET;
        end
        INIT_SET: state <= INIT_RUN;
        INIT_RUN: begin
          if (c11) state <= AD_WAIT;
        end
        AD_WAIT: begin
          if (data_valid_i) state <= AD_RUN;
        end
        AD_RUN: begin
          if (c11) begin
            ad_cnt <= ad_cnt + ADW'(1);
            state  <= ad_last ? PT_WAIT : AD_WAIT;
          end
        end
        PT_WAIT: begin
          if (data_valid_i)
            state <= pt_last ? FIN_RUN : PT_RUN;
        end
        PT_RUN: begin
          if (c11) begin
            pt_cnt <= pt_cnt + PTW'(1);
            state  <= PT_WAIT;
          end
        end
        FIN_RUN: begin
          if (c11) state <= DONE;
        end
        DONE: begin
          ad_cnt <= '0;
          pt_cnt <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    en_cpt_o            = 1'b0;
    init_a_o            = 1'b0;
    init_b_o            = 1'b0;
    init_state_sel_o    = 1'b0;
    en_reg_state_o      = 1'b0;
    en_xor_data_begin_o = 1'b0;
    en_xor_key_begin_o  = 1'b0;
    en_xor_key_end_o    = 1'b0;
    en_xor_lsb_end_o    = 1'b0;
    en_cipher_o         = 1'b0;
    en_tag_o            = 1'b0;
    data_ack_o          = 1'b0;
    busy_o              = (state != IDLE);
    done_o              = 1'b0;
    unique case (state)
      IDLE: ;
      INIT_SET: begin
        en_cpt_o = 1'b1;
        init_a_o = 1'b1;
      end
      INIT_RUN: begin
        en_cpt_o         = 1'b1;
        en_reg_state_o   = 1'b1;
        init_state_sel_o = c0;
        en_xor_key_end_o = c11;
      end
      AD_WAIT: begin
        en_cpt_o = data_valid_i;
        init_b_o = data_valid_i;
      end
      AD_RUN: begin
        en_cpt_o            = 1'b1;
        en_reg_state_o      = 1'b1;
        en_xor_data_begin_o = c6;
        data_ack_o          = c6;
        en_xor_lsb_end_o    = c11 & ad_last;
      end
      PT_WAIT: begin
        // Last PT block goes straight into finalisation p^12.
        en_cpt_o = data_valid_i;
        init_b_o = data_valid_i & ~pt_last;
        init_a_o = data_valid_i & pt_last;
      end
      PT_RUN: begin
        en_cpt_o            = 1'b1;
        en_reg_state_o      = 1'b1;
        en_xor_data_begin_o = c6;
        en_cipher_o         = c6;
        data_ack_o          = c6;
      end
      FIN_RUN: begin
        // Last PT block XOR and key XOR share the first round.
        en_cpt_o            = 1'b1;
        en_reg_state_o      = 1'b1;
        en_xor_data_begin_o = c0;
        en_cipher_o         = c0;
        data_ack_o          = c0;
        en_xor_key_begin_o  = c0;
        en_xor_key_end_o    = c11;
        en_tag_o            = c11;
      end
      DONE: done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ascon_fsm_ctrl.sv
// tb_ascon_fsm_ctrl: scoreboard bench for ascon_fsm_ctrl.
// Phase-level reference schedule, per-cycle output comparison.
module tb_ascon_fsm_ctrl;

  localparam logic [14:0] M_DONE = 15'd1 << 0;
  localparam logic [14:0] M_BUSY = 15'd1 << 1;
  localparam logic [14:0] M_CV   = 15'd1 << 2;
  localparam logic [14:0] M_ACK  = 15'd1 << 3;
  localparam logic [14:0] M_TAG  = 15'd1 << 4;
  localparam logic [14:0] M_CIPH = 15'd1 << 5;
  localparam logic [14:0] M_XLE  = 15'd1 << 6;
  localparam logic [14:0] M_XKE  = 15'd1 << 7;
  localparam logic [14:0] M_XKB  = 15'd1 << 8;
  localparam logic [14:0] M_XDB  = 15'd1 << 9;
  localparam logic [14:0] M_REG  = 15'd1 << 10;
  localparam logic [14:0] M_SEL  = 15'd1 << 11;
  localparam logic [14:0] M_INB  = 15'd1 << 12;
  localparam logic [14:0] M_INA  = 15'd1 << 13;
  localparam logic [14:0] M_CPT  = 15'd1 << 14;
  localparam logic [14:0] RUN    = M_BUSY | M_CPT | M_REG;

  typedef struct {
    bit          rst;
    bit          st4;
    bit          st1;
    bit          dv4;
    bit          dv1;
    logic [14:0] e4;
    logic [14:0] e1;
  } stim_t;

  typedef struct {
    int          c;
    logic [14:0] e4;
    logic [14:0] e1;
  } exp_t;

  logic clk;
  logic resetb;
  logic st4, st1, dv4, dv1;
  logic [3:0] cpt4, cpt1;

  logic en_cpt4, ina4, inb4, sel4, reg4, xdb4, xkb4, xke4;
  logic xle4, ciph4, tag4, ack4, cv4, busy4, done4;
  logic en_cpt1, ina1, inb1, sel1, reg1, xdb1, xkb1, xke1;
  logic xle1, ciph1, tag1, ack1, cv1, busy1, done1;

  stim_t stim_q[$];
  exp_t  sb_q[$];
  logic [14:0] prev_c[2];
  int exp_done_c[$];
  int exp_done_w[$];
  int seen0[$];
  int seen1[$];
  int tests;
  int fails;

  ascon_fsm_ctrl #(.NB_AD(1), .NB_PT(4)) dut4 (
    .clock_i(clk), .resetb_i(resetb), .start_i(st4),
    .data_valid_i(dv4), .cpt_i(cpt4), .en_cpt_o(en_cpt4),
    .init_a_o(ina4), .init_b_o(inb4), .init_state_sel_o(sel4),
    .en_reg_state_o(reg4), .en_xor_data_begin_o(xdb4),
    .en_xor_key_begin_o(xkb4), .en_xor_key_end_o(xke4),
    .en_xor_lsb_end_o(xle4), .en_cipher_o(ciph4), .en_tag_o(tag4),
    .data_ack_o(ack4), .cipher_valid_o(cv4), .busy_o(busy4),
    .done_o(done4)
  );

  ascon_fsm_ctrl #(.NB_AD(1), .NB_PT(1)) dut1 (
    .clock_i(clk), .resetb_i(resetb), .start_i(st1),
    .data_valid_i(dv1), .cpt_i(cpt1), .en_cpt_o(en_cpt1),
    .init_a_o(ina1), .init_b_o(inb1), .init_state_sel_o(sel1),
    .en_reg_state_o(reg1), .en_xor_data_begin_o(xdb1),
    .en_xor_key_begin_o(xkb1), .en_xor_key_end_o(xke1),
    .en_xor_lsb_end_o(xle1), .en_cipher_o(ciph1), .en_tag_o(tag1),
    .data_ack_o(ack1), .cipher_valid_o(cv1), .busy_o(busy1),
    .done_o(done1)
  );

  // External round counters: init_a loads 0, init_b loads 6.
  always @(posedge clk or negedge resetb) begin
    if (!resetb) cpt4 <= 4'd0;
    else if (en_cpt4) cpt4 <= ina4 ? 4'd0 : inb4 ? 4'd6 : cpt4 + 4'd1;
  end

  always @(posedge clk or negedge resetb) begin
    if (!resetb) cpt1 <= 4'd0;
    else if (en_cpt1) cpt1 <= ina1 ? 4'd0 : inb1 ? 4'd6 : cpt1 + 4'd1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] pk(bit st, bit dv, logic [14:0] e);
    return {st, dv, e};
  endfunction

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  // One cycle of stimulus; the idle instance sees random data_valid.
  task automatic cyc(int w, bit rst, bit st, bit dv, logic [14:0] e);
    stim_t s;
    logic [14:0] ev[2];
    bit stv[2];
    bit dvv[2];
    ev[0] = '0;
    ev[1] = '0;
    stv[0] = 1'b0;
    stv[1] = 1'b0;
    dvv[0] = rb();
    dvv[1] = rb();
    ev[w] = e;
    stv[w] = st;
    dvv[w] = dv;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        ev[i] = '0;
        stv[i] = 1'b0;
        prev_c[i] = '0;
      end else begin
        ev[i] = ev[i] | ((prev_c[i] != 0) ? M_CV : 15'd0);
        prev_c[i] = ev[i] & M_CIPH;
      end
    end
    s.rst = rst;
    s.st4 = stv[0];
    s.st1 = stv[1];
    s.dv4 = dvv[0];
    s.dv1 = dvv[1];
    s.e4 = ev[0];
    s.e1 = ev[1];
    stim_q.push_back(s);
  endtask

  task automatic idle(int n);
    repeat (n) cyc(0, 1'b0, 1'b0, rb(), '0);
  endtask

  task automatic wait_ph(ref logic [16:0] loc[$], input int stall);
    int s;
    s = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
    repeat (s) loc.push_back(pk(rb(), 1'b0, M_BUSY));
  endtask

  // Expected schedule of one encryption, phase by phase.
  // cut >= 0: reset is applied at relative cycle cut.
  task automatic run(int w, int nb_pt, int stall, int cut, int dn);
    logic [16:0] loc[$];
    logic [14:0] e;
    int n0;
    n0 = stim_q.size();
    loc.push_back(pk(1'b1, rb(), '0));
    loc.push_back(pk(rb(), rb(), M_BUSY | M_CPT | M_INA));
    for (int k = 0; k < 12; k++) begin
      e = RUN;
      if (k == 0) e = e | M_SEL;
      if (k == 11) e = e | M_XKE;
      loc.push_back(pk(rb(), rb(), e));
    end
    wait_ph(loc, stall);
    loc.push_back(pk(rb(), 1'b1, M_BUSY | M_CPT | M_INB));
    for (int k = 0; k < 6; k++) begin
      e = RUN;
      if (k == 0) e = e | M_XDB | M_ACK;
      if (k == 5) e = e | M_XLE;
      loc.push_back(pk(rb(), rb(), e));
    end
    for (int p = 0; p < nb_pt; p++) begin
      wait_ph(loc, stall);
      if (p < nb_pt - 1) begin
        loc.push_back(pk(rb(), 1'b1, M_BUSY | M_CPT | M_INB));
        for (int k = 0; k < 6; k++) begin
          e = RUN;
          if (k == 0) e = e | M_XDB | M_CIPH | M_ACK;
          loc.push_back(pk(rb(), rb(), e));
        end
      end else begin
        loc.push_back(pk(rb(), 1'b1, M_BUSY | M_CPT | M_INA));
      end
    end
    for (int k = 0; k < 12; k++) begin
      e = RUN;
      if (k == 0) e = e | M_XDB | M_CIPH | M_ACK | M_XKB;
      if (k == 11) e = e | M_XKE | M_TAG;
      loc.push_back(pk(rb(), rb(), e));
    end
    loc.push_back(pk(rb(), rb(), M_BUSY | M_DONE));
    for (int i = 0; i < loc.size(); i++) begin
      if (cut < 0 || i < cut)
        cyc(w, 1'b0, loc[i][16], loc[i][15], loc[i][14:0]);
    end
    if (cut >= 0) repeat (3) cyc(w, 1'b1, 1'b0, 1'b0, '0);
    if (dn > 0) begin
      exp_done_c.push_back(n0 + dn);
      exp_done_w.push_back(w);
    end
  endtask

  // Monitor: pops one expectation per cycle, samples on negedge.
  initial begin
    exp_t x;
    logic [14:0] o4, o1;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        o4 = {en_cpt4, ina4, inb4, sel4, reg4, xdb4, xkb4, xke4,
              xle4, ciph4, tag4, ack4, cv4, busy4, done4};
        o1 = {en_cpt1, ina1, inb1, sel1, reg1, xdb1, xkb1, xke1,
              xle1, ciph1, tag1, ack1, cv1, busy1, done1};
        tests++;
        if (o4 !== x.e4) begin
          fails++;
          $display("FAIL out_pt4 cyc=%0d got=%h exp=%h", x.c, o4, x.e4);
        end
        tests++;
        if (o1 !== x.e1) begin
          fails++;
          $display("FAIL out_pt1 cyc=%0d got=%h exp=%h", x.c, o1, x.e1);
        end
        if (done4 === 1'b1) seen0.push_back(x.c);
        if (done1 === 1'b1) seen1.push_back(x.c);
      end
    end
  end

  initial begin
    stim_t s;
    exp_t x;
    bit found;
    int w, cut;
    tests = 0;
    fails = 0;
    resetb = 1'b0;
    st4 = 1'b0;
    st1 = 1'b0;
    dv4 = 1'b0;
    dv1 = 1'b0;
    prev_c[0] = '0;
    prev_c[1] = '0;

    repeat (3) cyc(0, 1'b1, 1'b0, 1'b0, '0);
    idle(2);
    run(0, 4, 0, -1, 55);
    idle(3);
    run(0, 4, 5, -1, 80);
    idle(2);
    run(0, 4, 0, 24, 0);
    run(0, 4, 0, -1, 55);
    idle(2);
    run(1, 1, 0, -1, 34);
    idle(2);
    for (int r = 0; r < 8; r++) begin
      w = int'($urandom_range(0, 1));
      cut = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 60)) : -1;
      run(w, (w == 0) ? 4 : 1, -1, cut, 0);
      idle(int'($urandom_range(0, 3)));
    end
    idle(3);

    for (int i = 0; i < stim_q.size(); i++) begin
      @(posedge clk);
      #1;
      s = stim_q[i];
      resetb = ~s.rst;
      st4 = s.st4;
      st1 = s.st1;
      dv4 = s.dv4;
      dv1 = s.dv1;
      x.c = i;
      x.e4 = s.e4;
      x.e1 = s.e1;
      sb_q.push_back(x);
    end
    @(posedge clk);
    @(negedge clk);
    #1;

    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain left=%0d exp=0", sb_q.size());
    end
    for (int i = 0; i < exp_done_c.size(); i++) begin
      found = 1'b0;
      if (exp_done_w[i] == 0) begin
        foreach (seen0[j]) if (seen0[j] == exp_done_c[i]) found = 1'b1;
      end else begin
        foreach (seen1[j]) if (seen1[j] == exp_done_c[i]) found = 1'b1;
      end
      tests++;
      if (!found) begin
        fails++;
        $display("FAIL done_timing inst=%0d got=absent exp_cyc=%0d",
                 exp_done_w[i], exp_done_c[i]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
